// File: rtl/test_fifo_param_if.sv
// test_fifo_param_if: producer/consumer bundle for test_fifo_param.
// Params: WIDTH data width, DEPTH entries (sets count width CW).
// master drives push/push_data/pop/clr_err and observes pop_data, the
// count, the level flags and the sticky errors; slave is the FIFO side.
interface test_fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             pop;
    logic [WIDTH-1:0] pop_data;
    logic             full;
    logic             afull;
    logic             empty;
    logic             aempty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
    logic             clr_err;
    modport master (
        output push, push_data, pop, clr_err,
        input  pop_data, full, afull, empty, aempty, count, overflow, underflow
    );
    modport slave (
        input  push, push_data, pop, clr_err,
        output pop_data, full, afull, empty, aempty, count, overflow, underflow
    );
endinterface

// File: rtl/test_fifo_param.sv
// test_fifo_param: parametrised synchronous show-ahead FIFO with occupancy count, level flags and sticky errors.
// Ports: clk, rst (sync, active-high), bus (test_fifo_param_if.slave):
//   push/push_data write side, pop/pop_data read side (pop_data shows the head),
//   full/afull/empty/aempty/count decoded from the registered count,
//   overflow/underflow sticky error flags cleared by clr_err.
// Optional: define TEST_FIFO_BYPASS_EN to let a push+pop on an empty FIFO pass
// the written word straight to pop_data without storing it.
module test_fifo_param #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 1
) (
    input  logic               clk,
    input  logic               rst,
    test_fifo_param_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AE_C   = CW'(AEMPTY_LVL);

    if (WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        AFULL_LVL < 0 || AFULL_LVL > DEPTH || AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH) begin : g_bad_param
        $error("test_fifo_param: parameter out of range");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic             ovf, unf;
    logic             bypass, wr_en, rd_en;

`ifdef TEST_FIFO_BYPASS_EN
    assign bypass = bus.empty && bus.push && bus.pop;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word is consumed in flight, so neither pointer moves.
    assign wr_en = bus.push && (!bus.full || bus.pop) && !bypass;
    assign rd_en = bus.pop && !bus.empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_en);
            rd_ptr <= rd_ptr + AW'(rd_en);
            cnt    <= cnt + CW'(wr_en) - CW'(rd_en);
            // A new error in the same cycle as clr_err keeps the flag set.
            ovf    <= (bus.push && bus.full && !bus.pop) || (ovf && !bus.clr_err);
            unf    <= (bus.pop && bus.empty && !bypass) || (unf && !bus.clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem[wr_ptr] <= bus.push_data;
    end

    assign bus.pop_data  = bypass ? bus.push_data : mem[rd_ptr];
    assign bus.count     = cnt;
    assign bus.full      = cnt == FULL_C;
    assign bus.afull     = cnt >= AF_C;
    assign bus.empty     = cnt == '0;
    assign bus.aempty    = cnt <= AE_C;
    assign bus.overflow  = ovf;
    assign bus.underflow = unf;
endmodule

// File: tb/tb_test_fifo_param.sv
// tb_test_fifo_param: directed table-driven bench for test_fifo_param (DEPTH=8) plus a DEPTH=4 pointer-wrap run.
module tb_test_fifo_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    test_fifo_param_if #(.WIDTH(8), .DEPTH(8)) a_if ();
    test_fifo_param_if #(.WIDTH(8), .DEPTH(4)) b_if ();

    test_fifo_param #(.WIDTH(8), .DEPTH(8)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    test_fifo_param #(.WIDTH(8), .DEPTH(4)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    typedef struct {
        logic       push;
        logic [7:0] d;
        logic       pop;
        logic       clr;
        logic       r;
        int         cnt;
        logic       ovf;
        logic       unf;
        logic       chk;
        logic [7:0] data;
    } vec_t;

    vec_t v[$];

    function automatic vec_t mk(input logic ps, input logic [7:0] d, input logic pp, input logic clr,
                                input logic r, input int c, input logic o, input logic u,
                                input logic ck, input logic [7:0] dt);
        vec_t t;
        t.push = ps; t.d = d; t.pop = pp; t.clr = clr; t.r = r;
        t.cnt = c; t.ovf = o; t.unf = u; t.chk = ck; t.data = dt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected flags for DEPTH=8: afull at >=6, aempty at <=1.
    task automatic chk_state(input string tag, input int c, input logic o, input logic u);
        chk({tag, ".count"}, 32'(a_if.count), 32'(c));
        chk({tag, ".empty"}, 32'(a_if.empty), 32'(c == 0));
        chk({tag, ".full"}, 32'(a_if.full), 32'(c == 8));
        chk({tag, ".afull"}, 32'(a_if.afull), 32'(c >= 6));
        chk({tag, ".aempty"}, 32'(a_if.aempty), 32'(c <= 1));
        chk({tag, ".overflow"}, 32'(a_if.overflow), 32'(o));
        chk({tag, ".underflow"}, 32'(a_if.underflow), 32'(u));
    endtask

    task automatic idle_a();
        a_if.push = 1'b0; a_if.push_data = 8'h00; a_if.pop = 1'b0; a_if.clr_err = 1'b0;
    endtask

    initial begin
        int q[$];
        logic dp, ds;
        idle_a();
        b_if.push = 1'b0; b_if.push_data = 8'h00; b_if.pop = 1'b0; b_if.clr_err = 1'b0;

        v.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00));
        v.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00));
        for (int k = 1; k <= 8; k++) v.push_back(mk(1, 8'(k), 0, 0, 0, k, 0, 0, 1, 8'h01));
        v.push_back(mk(1, 8'hAA, 0, 0, 0, 8, 1, 0, 1, 8'h01));
        v.push_back(mk(0, 8'h00, 0, 1, 0, 8, 0, 0, 1, 8'h01));
        v.push_back(mk(1, 8'h55, 1, 0, 0, 8, 0, 0, 1, 8'h02));
        for (int k = 3; k <= 8; k++) v.push_back(mk(0, 8'h00, 1, 0, 0, 10 - k, 0, 0, 1, 8'(k)));
        v.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 1, 8'h55));
        v.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h00));
        v.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 8'h00));
        v.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 1, 0, 8'h00));
        v.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 8'h00));
        for (int k = 1; k <= 5; k++) v.push_back(mk(1, 8'(8'h10 + k), 0, 0, 0, k, 0, 0, 1, 8'h11));
        v.push_back(mk(1, 8'hEE, 1, 0, 1, 0, 0, 0, 0, 8'h00));
        v.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00));

        foreach (v[i]) begin
            @(negedge clk);
            a_if.push = v[i].push; a_if.push_data = v[i].d; a_if.pop = v[i].pop;
            a_if.clr_err = v[i].clr; rst = v[i].r;
            @(posedge clk);
            #1;
            chk_state($sformatf("vec%0d", i), v[i].cnt, v[i].ovf, v[i].unf);
            if (v[i].chk) chk($sformatf("vec%0d.pop_data", i), 32'(a_if.pop_data), 32'(v[i].data));
        end

        @(negedge clk);
        rst = 1'b0;
        a_if.push = 1'b1; a_if.push_data = 8'h3C; a_if.pop = 1'b1;
        #1;
`ifdef TEST_FIFO_BYPASS_EN
        chk("bypass.pop_data_same_cycle", 32'(a_if.pop_data), 32'h3C);
`endif
        @(posedge clk);
        #1;
`ifdef TEST_FIFO_BYPASS_EN
        chk_state("bypass", 0, 0, 0);
`else
        chk_state("empty_push_pop", 1, 0, 1);
        chk("empty_push_pop.pop_data", 32'(a_if.pop_data), 32'h3C);
`endif
        @(negedge clk);
        idle_a();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_state("rst2", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            dp = (i % 3 != 0) && (q.size() > 0);
            ds = (i % 4 != 3) && (q.size() < 4 || dp);
            b_if.pop = dp; b_if.push = ds; b_if.push_data = 8'(8'h40 + i);
            if (dp) chk($sformatf("wrap%0d.pop_data", i), 32'(b_if.pop_data), 32'(q[0]));
            @(posedge clk);
            if (dp) void'(q.pop_front());
            if (ds) q.push_back(8'h40 + i);
        end
        @(negedge clk);
        b_if.push = 1'b0; b_if.pop = 1'b0;
        chk("wrap.count", 32'(b_if.count), 32'(q.size()));
        chk("wrap.overflow", 32'(b_if.overflow), 32'h0);
        chk("wrap.underflow", 32'(b_if.underflow), 32'h0);
        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            @(negedge clk);
            b_if.pop = 1'b1;
            chk($sformatf("drain%0d.pop_data", i), 32'(b_if.pop_data), 32'(q[0]));
            @(posedge clk);
            void'(q.pop_front());
        end
        @(negedge clk);
        b_if.pop = 1'b0;
        chk("drain.empty", 32'(b_if.empty), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
